// File: rtl/ram_multi_read_port.sv
// Multi-read-port lane-masked RAM with a power-on/iClear zeroing sweep.
// Optional macro RAM_WRITE_BYPASS_EN: same-address reads see the masked write data.
module ram_multi_read_port #(
  parameter int DATA_WIDTH = 96,
  parameter int LANE_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 128,
  parameter int READ_PORTS = 2
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iClear,
  input  logic                             iWriteEnable,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] iWriteLaneMask,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic [READ_PORTS-1:0]            iReadEnable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic                             oReady
);

  // state | meaning
  // ------+-------------------------------------------------------------
  // CLEAR | sweeping zeros through the array, one word per cycle
  // READY | array usable: masked writes and per-port registered reads

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT  = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_count;
  logic [DATA_WIDTH-1:0]   ram [0:MEM_SIZE-1];
  logic [DATA_WIDTH-1:0]   data_q [READ_PORTS];
  logic [DATA_WIDTH-1:0]   rd_word [READ_PORTS];
  logic [ADDR_WIDTH-1:0]   rd_addr [READ_PORTS];
  logic                    wr_fire;
  logic                    wr_in_range;

  assign wr_in_range = ({1'b0, iWriteAddress} < MEM_LIMIT);

  always_comb begin
    wr_fire = (state == READY) && !iClear && iWriteEnable && wr_in_range;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p] = iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word[p] = ({1'b0, rd_addr[p]} < MEM_LIMIT) ? ram[rd_addr[p]] : '0;
`ifdef RAM_WRITE_BYPASS_EN
      if (wr_fire && (rd_addr[p] == iWriteAddress)) begin
        for (int k = 0; k < LANES; k++) begin
          if (iWriteLaneMask[k]) begin
            rd_word[p][k*LANE_WIDTH +: LANE_WIDTH] = iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
`endif
    end
  end

  // Array storage has no reset; only the CLEAR sweep zeroes it.
  always_ff @(posedge Clock) begin
    if (state == CLEAR) begin
      ram[clear_count] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (iWriteLaneMask[k]) begin
          ram[iWriteAddress][k*LANE_WIDTH +: LANE_WIDTH] <= iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= CLEAR;
      clear_count <= '0;
      oReady      <= 1'b0;
      for (int p = 0; p < READ_PORTS; p++) data_q[p] <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_count == LAST_ADDR) begin
            state       <= READY;
            oReady      <= 1'b1;
            clear_count <= '0;
          end else begin
            clear_count <= clear_count + 1'b1;
          end
        end
        READY: begin
          if (iClear) begin
            state       <= CLEAR;
            oReady      <= 1'b0;
            clear_count <= '0;
          end
        end
        default: begin
          state       <= CLEAR;
          oReady      <= 1'b0;
          clear_count <= '0;
        end
      endcase

      // Outputs read as zero for the whole sweep, including the entry edge.
      for (int p = 0; p < READ_PORTS; p++) begin
        if ((state != READY) || iClear) begin
          data_q[p] <= '0;
        end else if (iReadEnable[p]) begin
          data_q[p] <= rd_word[p];
        end
      end
    end
  end

  always_comb begin
    oDataOut = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      oDataOut[p*DATA_WIDTH +: DATA_WIDTH] = data_q[p];
    end
  end

endmodule

// File: tb/tb_ram_multi_read_port.sv
// Self-checking bench for ram_multi_read_port: directed scenarios plus random traffic
// checked against an array-based behavioural model.
module tb_ram_multi_read_port;

  localparam int DW  = 96;
  localparam int LW  = 32;
  localparam int AW  = 7;
  localparam int MEM = 128;
  localparam int RP  = 2;
  localparam int LN  = DW / LW;

  logic            Clock;
  logic            Reset;
  logic            iClear;
  logic            iWriteEnable;
  logic [LN-1:0]   iWriteLaneMask;
  logic [AW-1:0]   iWriteAddress;
  logic [DW-1:0]   iDataIn;
  logic [RP-1:0]   iReadEnable;
  logic [RP*AW-1:0] iReadAddress;
  logic [RP*DW-1:0] oDataOut;
  logic            oReady;

  ram_multi_read_port #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM), .READ_PORTS(RP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iClear(iClear), .iWriteEnable(iWriteEnable),
    .iWriteLaneMask(iWriteLaneMask), .iWriteAddress(iWriteAddress), .iDataIn(iDataIn),
    .iReadEnable(iReadEnable), .iReadAddress(iReadAddress), .oDataOut(oDataOut),
    .oReady(oReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [MEM];
  logic [DW-1:0] m_out [RP];
  logic          m_ready;
  int            m_sweep;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", {{(DW-1){1'b0}}, oReady}, {{(DW-1){1'b0}}, m_ready});
    for (int p = 0; p < RP; p++)
      chk(p == 0 ? "port0" : "port1", oDataOut[p*DW +: DW], m_out[p]);
  endtask

  // Advance the model by one edge from the current inputs, then compare after the edge.
  task automatic tick();
    logic [DW-1:0] word;
    logic [AW-1:0] ra;
    if (!m_ready) begin
      m_mem[m_sweep] = '0;
      m_sweep++;
      if (m_sweep == MEM) m_ready = 1'b1;
      for (int p = 0; p < RP; p++) m_out[p] = '0;
    end else if (iClear) begin
      m_ready = 1'b0;
      m_sweep = 0;
      for (int p = 0; p < RP; p++) m_out[p] = '0;
    end else begin
      for (int p = 0; p < RP; p++) begin
        if (iReadEnable[p]) begin
          ra = iReadAddress[p*AW +: AW];
          word = (int'(ra) < MEM) ? m_mem[ra] : '0;
`ifdef RAM_WRITE_BYPASS_EN
          if (iWriteEnable && ra == iWriteAddress)
            for (int k = 0; k < LN; k++)
              if (iWriteLaneMask[k]) word[k*LW +: LW] = iDataIn[k*LW +: LW];
`endif
          m_out[p] = word;
        end
      end
      if (iWriteEnable && int'(iWriteAddress) < MEM)
        for (int k = 0; k < LN; k++)
          if (iWriteLaneMask[k]) m_mem[iWriteAddress][k*LW +: LW] = iDataIn[k*LW +: LW];
    end
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    iClear = 1'b0; iWriteEnable = 1'b0; iWriteLaneMask = '0; iWriteAddress = '0;
    iDataIn = '0; iReadEnable = '0; iReadAddress = '0;
  endtask

  task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] m);
    iWriteEnable = 1'b1; iWriteAddress = a; iDataIn = d; iWriteLaneMask = m;
  endtask

  task automatic set_read(input int p, input logic [AW-1:0] a);
    iReadEnable[p] = 1'b1;
    iReadAddress[p*AW +: AW] = a;
  endtask

  task automatic reset_assert();
    Reset = 1'b0;
    m_ready = 1'b0;
    m_sweep = 0;
    for (int p = 0; p < RP; p++) m_out[p] = '0;
    #1;
    check_all();
  endtask

  // Returns the number of edges until oReady rises (bounded).
  task automatic count_to_ready(output int n);
    n = 0;
    while (!oReady && n < 300) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < MEM; i++) m_mem[i] = '0;
    set_idle();
    #2;
    reset_assert();
    #20;
    Reset = 1'b1;

    // Sweep after reset release: ready on the 128th edge, every word zero.
    count_to_ready(n);
    chk("sweep_edges", DW'(n), DW'(128));
    for (int a = 0; a < MEM; a += 2) begin
      set_read(0, AW'(a));
      set_read(1, AW'(a + 1));
      tick();
    end
    set_idle();

    // Full write then lane-1-only rewrite of address 5.
    set_write(7'd5, 96'h33333333_22222222_11111111, 3'b111); tick();
    set_write(7'd5, 96'hDEADBEEF_AAAAAAAA_CAFEF00D, 3'b010); tick();
    set_write(7'd5, 96'h0, 3'b000); tick();
    set_idle();
    set_read(0, 7'd5); set_read(1, 7'd5); tick();
    chk("lane_mask_p0", oDataOut[0 +: DW], 96'h33333333_AAAAAAAA_11111111);
    chk("lane_mask_p1", oDataOut[DW +: DW], 96'h33333333_AAAAAAAA_11111111);

    // Read-during-write on address 9.
    set_idle();
    set_write(7'd9, {DW{1'b1}}, 3'b111);
    set_read(0, 7'd9); set_read(1, 7'd9); tick();
`ifdef RAM_WRITE_BYPASS_EN
    chk("rdw_p0", oDataOut[0 +: DW], {DW{1'b1}});
    chk("rdw_p1", oDataOut[DW +: DW], {DW{1'b1}});
`else
    chk("rdw_p0", oDataOut[0 +: DW], 96'h0);
    chk("rdw_p1", oDataOut[DW +: DW], 96'h0);
`endif
    iWriteEnable = 1'b0; tick();
    chk("rdw_after_p0", oDataOut[0 +: DW], {DW{1'b1}});
    chk("rdw_after_p1", oDataOut[DW +: DW], {DW{1'b1}});

    // Port 1 holds while port 0 tracks.
    set_idle();
    set_write(7'd20, 96'h1234, 3'b111); tick();
    set_write(7'd21, 96'h5555, 3'b111); tick();
    set_write(7'd22, 96'h6666, 3'b111); tick();
    set_idle();
    set_read(0, 7'd20); set_read(1, 7'd20); tick();
    chk("hold_first_p1", oDataOut[DW +: DW], 96'h1234);
    iReadEnable[1] = 1'b0; iReadAddress[0 +: AW] = 7'd21; tick();
    chk("track_p0_a", oDataOut[0 +: DW], 96'h5555);
    chk("hold_p1_a", oDataOut[DW +: DW], 96'h1234);
    iReadAddress[0 +: AW] = 7'd22; iReadAddress[AW +: AW] = 7'd21; tick();
    chk("track_p0_b", oDataOut[0 +: DW], 96'h6666);
    chk("hold_p1_b", oDataOut[DW +: DW], 96'h1234);

    // Random traffic, concentrated on a few addresses to force collisions.
    for (int i = 0; i < 400; i++) begin
      iClear         = ($urandom_range(0, 149) == 0);
      iWriteEnable   = $urandom_range(0, 1) == 1;
      iWriteLaneMask = LN'($urandom_range(0, 7));
      iWriteAddress  = AW'($urandom_range(0, 15));
      iDataIn        = {$urandom, $urandom, $urandom};
      iReadEnable    = RP'($urandom_range(0, 3));
      iReadAddress   = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      tick();
    end
    set_idle();
    count_to_ready(n);
    chk("random_recover", {{(DW-1){1'b0}}, oReady}, {{(DW-1){1'b0}}, 1'b1});

    // iClear with a same-cycle write: write dropped, full sweep, address 3 reads zero.
    set_write(7'd3, 96'hABCD, 3'b111); tick();
    set_idle();
    set_read(0, 7'd3); tick();
    chk("pre_clear_a3", oDataOut[0 +: DW], 96'hABCD);
    set_idle();
    iClear = 1'b1;
    set_write(7'd3, 96'h7777, 3'b111);
    tick();
    chk("clear_entry_ready", {{(DW-1){1'b0}}, oReady}, '0);
    set_idle();
    set_read(0, 7'd3);
    count_to_ready(n);
    chk("clear_edges", DW'(n), DW'(128));
    set_read(0, 7'd3); set_read(1, 7'd3); tick();
    chk("cleared_a3_p0", oDataOut[0 +: DW], 96'h0);
    chk("cleared_a3_p1", oDataOut[DW +: DW], 96'h0);

    // Reset pulsed 40 words into a sweep restarts the full sweep.
    set_idle();
    set_write(7'd100, 96'h4242, 3'b111); tick();
    set_idle();
    iClear = 1'b1; tick();
    iClear = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    #2;
    reset_assert();
    #1;
    Reset = 1'b1;
    count_to_ready(n);
    chk("restart_edges", DW'(n), DW'(128));
    set_read(0, 7'd100); tick();
    chk("restart_a100", oDataOut[0 +: DW], 96'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
